// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer with branch/jump redirect,
// single-level interrupt entry/return and a halt state.
//
// Ports:
//   iClk, iRst_n      clock (rising edge), asynchronous active-low reset
//   iStall            hold the PC; branch/jump still redirect
//   iBranchTaken/iBranchTarget, iJump/iJumpTarget   redirect requests
//   iIrq              level interrupt request, held until oIrqAck
//   iIret             return from interrupt (honoured in ISR only)
//   iHalt/iResume     enter / leave HALTED
//   oPC               current fetch address
//   oEPC              saved return address (written on interrupt entry only)
//   oFetchValid       oPC is a valid fetch this cycle
//   oIrqAck           one-cycle pulse, high in the cycle oPC first shows IRQ_VEC
//   oHalted           high while in HALTED
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h0000_0100
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [31:0] iBranchTarget,
    input  logic        iJump,
    input  logic [31:0] iJumpTarget,
    input  logic        iIrq,
    input  logic        iIret,
    input  logic        iHalt,
    input  logic        iResume,
    output logic [31:0] oPC,
    output logic [31:0] oEPC,
    output logic        oFetchValid,
    output logic        oIrqAck,
    output logic        oHalted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISR    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        halt_from_isr_q, halt_from_isr_d;
    logic        irq_ack_q, irq_ack_d;
    logic [31:0] pc_plus4;

    // Wraps naturally at 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        epc_d           = epc_q;
        halt_from_isr_d = halt_from_isr_q;
        irq_ack_d       = 1'b0;

        if (state_q == HALTED) begin
            // Interrupt wake beats resume, but only when the halt came from RUN
            // (an ISR that halted must not be re-entered).
            if (iIrq && !halt_from_isr_q) begin
                epc_d     = pc_plus4 & ALIGN_MASK;
                pc_d      = IRQ_VEC;
                irq_ack_d = 1'b1;
                state_d   = ISR;
            end else if (iResume) begin
                pc_d    = pc_plus4;
                state_d = halt_from_isr_q ? ISR : RUN;
            end
        end else begin
            // Redirects override stall; everything else waits for !iStall.
            if (iBranchTaken) begin
                pc_d = iBranchTarget & ALIGN_MASK;
            end else if (iJump) begin
                pc_d = iJumpTarget & ALIGN_MASK;
            end else if (!iStall && state_q == RUN && iIrq) begin
                epc_d     = pc_plus4 & ALIGN_MASK;
                pc_d      = IRQ_VEC;
                irq_ack_d = 1'b1;
                state_d   = ISR;
            end else if (!iStall && state_q == ISR && iIret) begin
                pc_d    = epc_q;
                state_d = RUN;
            end else if (!iStall && iHalt) begin
                halt_from_isr_d = (state_q == ISR);
                state_d         = HALTED;
            end else if (!iStall) begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q         <= RUN;
            pc_q            <= RESET_VEC;
            epc_q           <= 32'h0;
            halt_from_isr_q <= 1'b0;
            irq_ack_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            epc_q           <= epc_d;
            halt_from_isr_q <= halt_from_isr_d;
            irq_ack_q       <= irq_ack_d;
        end
    end

    assign oPC         = pc_q;
    assign oEPC        = epc_q;
    assign oIrqAck     = irq_ack_q;
    assign oHalted     = (state_q == HALTED);
    assign oFetchValid = (state_q != HALTED) && !iStall;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iStall, iBranchTaken, iJump, iIrq, iIret, iHalt, iResume;
    logic [31:0] iBranchTarget, iJumpTarget;
    logic [31:0] oPC, oEPC;
    logic        oFetchValid, oIrqAck, oHalted;

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    pc_sequencer dut (
        .iClk(iClk), .iRst_n(iRst_n), .iStall(iStall),
        .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iJump(iJump), .iJumpTarget(iJumpTarget), .iIrq(iIrq), .iIret(iIret),
        .iHalt(iHalt), .iResume(iResume), .oPC(oPC), .oEPC(oEPC),
        .oFetchValid(oFetchValid), .oIrqAck(oIrqAck), .oHalted(oHalted)
    );

    typedef struct {
        string       name;
        logic        stall, br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        irq, iret, halt, resume;
        logic [31:0] pc, epc;
        logic        fv, ack, hlt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic stall, logic br, logic [31:0] bt,
                                logic jmp, logic [31:0] jt, logic irq, logic iret,
                                logic halt, logic resume, logic [31:0] pc,
                                logic [31:0] epc, logic fv, logic ack, logic hlt);
        vec_t v;
        v.name = name; v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.irq = irq; v.iret = iret; v.halt = halt; v.resume = resume;
        v.pc = pc; v.epc = epc; v.fv = fv; v.ack = ack; v.hlt = hlt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(logic stall, logic br, logic [31:0] bt, logic jmp,
                         logic [31:0] jt, logic irq, logic iret, logic halt,
                         logic resume);
        iStall = stall; iBranchTaken = br; iBranchTarget = bt; iJump = jmp;
        iJumpTarget = jt; iIrq = irq; iIret = iret; iHalt = halt; iResume = resume;
    endtask

    task automatic chk_all(string n, logic [31:0] pc, logic [31:0] epc,
                           logic fv, logic ack, logic hlt);
        chk({n, ".pc"}, oPC, pc);
        chk({n, ".epc"}, oEPC, epc);
        chk({n, ".fv"}, {31'b0, oFetchValid}, {31'b0, fv});
        chk({n, ".ack"}, {31'b0, oIrqAck}, {31'b0, ack});
        chk({n, ".hlt"}, {31'b0, oHalted}, {31'b0, hlt});
    endtask

    initial begin
        //                 name         stl br bt            jmp jt            irq ire hlt res  pc            epc          fv ack hlt
        tbl.push_back(mk("idle1",       0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h4,        32'h0,   1, 0, 0));
        tbl.push_back(mk("idle2",       0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h8,        32'h0,   1, 0, 0));
        tbl.push_back(mk("idle3",       0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'hC,        32'h0,   1, 0, 0));
        tbl.push_back(mk("jmp20",       0, 0, 32'h0,        1, 32'h20,       0, 0, 0, 0, 32'h20,       32'h0,   1, 0, 0));
        tbl.push_back(mk("br_prio",     1, 1, 32'h103,      1, 32'h200,      0, 0, 0, 0, 32'h100,      32'h0,   0, 0, 0));
        tbl.push_back(mk("stall_hold",  1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h100,      32'h0,   0, 0, 0));
        tbl.push_back(mk("stall_irq",   1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h100,      32'h0,   0, 0, 0));
        tbl.push_back(mk("jmp40",       0, 0, 32'h0,        1, 32'h40,       0, 0, 0, 0, 32'h40,       32'h0,   1, 0, 0));
        tbl.push_back(mk("irq_take",    0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h100,      32'h44,  1, 1, 0));
        tbl.push_back(mk("irq_nonest",  0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h104,      32'h44,  1, 0, 0));
        tbl.push_back(mk("iret",        0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h44,       32'h44,  1, 0, 0));
        tbl.push_back(mk("iret_run",    0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h48,       32'h44,  1, 0, 0));
        tbl.push_back(mk("jmp80",       0, 0, 32'h0,        1, 32'h80,       0, 0, 0, 0, 32'h80,       32'h44,  1, 0, 0));
        tbl.push_back(mk("halt",        0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 32'h80,       32'h44,  0, 0, 1));
        tbl.push_back(mk("halt_ignbr",  0, 1, 32'h300,      1, 32'h400,      0, 1, 0, 0, 32'h80,       32'h44,  0, 0, 1));
        tbl.push_back(mk("halt_wake",   0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 1, 32'h100,      32'h84,  1, 1, 0));
        tbl.push_back(mk("isr_halt",    0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 32'h100,      32'h84,  0, 0, 1));
        tbl.push_back(mk("isrhalt_irq", 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h100,      32'h84,  0, 0, 1));
        tbl.push_back(mk("resume_isr",  0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h104,      32'h84,  1, 0, 0));
        tbl.push_back(mk("iret2",       0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 0, 32'h84,       32'h84,  1, 0, 0));
        tbl.push_back(mk("halt_stall",  1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 32'h84,       32'h84,  0, 0, 0));
        tbl.push_back(mk("halt_run",    0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0, 32'h84,       32'h84,  0, 0, 1));
        tbl.push_back(mk("resume_run",  0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h88,       32'h84,  1, 0, 0));
        tbl.push_back(mk("jmp_top",     0, 0, 32'h0,        1, 32'hFFFF_FFFF,0, 0, 0, 0, 32'hFFFF_FFFC,32'h84,  1, 0, 0));
        tbl.push_back(mk("wrap",        0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h84,  1, 0, 0));
        tbl.push_back(mk("br_align",    0, 1, 32'h12,       0, 32'h0,        0, 0, 0, 0, 32'h10,       32'h84,  1, 0, 0));
        tbl.push_back(mk("irq2",        0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0, 32'h100,      32'h14,  1, 1, 0));

        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        iRst_n = 1'b0;
        #12;
        chk_all("reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge iClk);
        iRst_n = 1'b1;
        #1;
        chk_all("first_fetch", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt,
                  tbl[i].irq, tbl[i].iret, tbl[i].halt, tbl[i].resume);
            @(posedge iClk);
            #1;
            chk_all(tbl[i].name, tbl[i].pc, tbl[i].epc, tbl[i].fv, tbl[i].ack, tbl[i].hlt);
        end

        // Asynchronous reset in the middle of an ISR (ack still high here).
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        #2;
        iRst_n = 1'b0;
        #1;
        chk_all("async_rst_isr", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge iClk);
        iRst_n = 1'b1;
        // State must be RUN again: iret ignored, irq accepted.
        drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0);
        @(posedge iClk); #1;
        chk_all("post_rst_iret", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
        @(posedge iClk); #1;
        chk_all("post_rst_irq", 32'h100, 32'h8, 1'b1, 1'b1, 1'b0);

        // Halt from ISR, then reset: halt origin must not survive reset.
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
        @(posedge iClk); #1;
        chk_all("isr_halt2", 32'h100, 32'h8, 1'b0, 1'b0, 1'b1);
        #2;
        iRst_n = 1'b0;
        #1;
        chk_all("async_rst_halt", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge iClk);
        iRst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 0);
        @(posedge iClk); #1;
        chk_all("rehalt", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Came from RUN, so an interrupt wakes it.
        drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 0);
        @(posedge iClk); #1;
        chk_all("rehalt_wake", 32'h100, 32'h4, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter IRQ_VEC, default 32'h0000_0100, PC loaded on interrupt entry.
REQ-003 SHALL have port iClk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iStall  in  1  pipeline stall; hold PC.
REQ-006 SHALL have port iBranchTaken  in  1  branch redirect request.
REQ-007 SHALL have port iBranchTarget  in  32  branch destination.
REQ-008 SHALL have port iJump  in  1  jump redirect request.
REQ-009 SHALL have port iJumpTarget  in  32  jump destination.
REQ-010 SHALL have port iIrq  in  1  level interrupt request, held by the requester until oIrqAck.
REQ-011 SHALL have port iIret  in  1  return from interrupt.
REQ-012 SHALL have port iHalt  in  1  halt request.
REQ-013 SHALL have port iResume  in  1  leave halt.
REQ-014 SHALL have port oPC  out  32  current fetch address.
REQ-015 SHALL have port oEPC  out  32  saved return address.
REQ-016 SHALL have port oFetchValid  out  1  oPC valid for fetch this cycle.
REQ-017 SHALL have port oIrqAck  out  1  one-cycle interrupt-accept pulse.
REQ-018 SHALL have port oHalted  out  1  high while in HALTED.

Function
REQ-019 SHALL implement FSM states RUN, ISR, HALTED, plus a 1-bit register haltFromIsr recording the state HALTED was entered from.
REQ-020 SHALL, in RUN or ISR, select next PC with this priority: iBranchTaken, then iJump, then (if !iStall) interrupt entry, then iIret (ISR only), then iHalt, then iStall hold, then oPC+4.
REQ-021 SHALL let branch/jump redirects override iStall; iIrq, iIret and iHalt SHALL wait while iStall=1.
REQ-022 SHALL force bits [1:0] of every loaded target (branch, jump, EPC) to 0.
REQ-023 SHALL compute oPC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 SHALL accept an interrupt only in RUN with iIrq=1 and iStall=0: oEPC <= oPC+4, oPC <= IRQ_VEC, oIrqAck=1 for that cycle, state -> ISR.
REQ-025 SHALL ignore iIrq in ISR (no nesting); the request stays pending until return to RUN.
REQ-026 SHALL, on iIret in ISR with no redirect: oPC <= oEPC, state -> RUN; iIret in RUN or HALTED SHALL be ignored.
REQ-027 SHALL, on iHalt: hold oPC unchanged, state -> HALTED, haltFromIsr <= (state==ISR).
REQ-028 SHALL, in HALTED, hold oPC and ignore iStall, iBranchTaken, iJump, iIret.
REQ-029 SHALL, in HALTED with iResume=1: oPC <= oPC+4, state -> ISR if haltFromIsr else RUN.
REQ-030 SHALL, in HALTED with iIrq=1 and haltFromIsr=0: treat as wake, oEPC <= oPC+4, oPC <= IRQ_VEC, oIrqAck=1, state -> ISR; iIrq SHALL take priority over a simultaneous iResume.
REQ-031 SHALL drive oFetchValid = (state != HALTED) && !iStall, combinationally from registered state.
REQ-032 SHALL drive oHalted = (state == HALTED), registered-state decode.
REQ-033 SHALL change oEPC only on interrupt entry.

Reset
REQ-034 SHALL, while iRst_n=0, immediately force oPC=RESET_VEC, oEPC=0, state=RUN, haltFromIsr=0, oIrqAck=0, oHalted=0.
REQ-035 SHALL abort any in-progress ISR or HALTED on reset assertion mid-operation, with no residual state.
REQ-036 SHALL fetch RESET_VEC as the first valid address after iRst_n rises, with oFetchValid=1 provided iStall=0.

Verification
REQ-037 Reset release, no inputs for 3 cycles -> oPC 0x0, 0x4, 0x8, 0xC; oFetchValid=1.
REQ-038 At oPC=0x20: iBranchTaken=1, iBranchTarget=0x103 and iJump=1 same cycle, with iStall=1 -> next oPC=0x100.
REQ-039 At oPC=0x40 in RUN: iIrq=1 -> oIrqAck pulse, oPC=0x100, oEPC=0x44; iIrq held in ISR -> no second ack; iIret -> oPC=0x44, RUN.
REQ-040 At oPC=0x80: iHalt=1 -> oHalted=1, oPC stays 0x80, oFetchValid=0; iIrq and iResume together -> oPC=0x100, oEPC=0x84, oIrqAck=1.
REQ-041 Force oPC=0xFFFF_FFFC by jump -> next oPC=0x0; assert iRst_n=0 mid-ISR -> oPC=RESET_VEC, oEPC=0, oHalted=0 asynchronously.
